dmem_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/arb_starve_ctr.sv | 28 ++
 rtl/dmem_arbiter.sv | 98 +++++++++
 tb/tb_dmem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types and defaults for the data-memory path.
// Widths match the 256x8 dat_mem.
package cpu_pkg;

  localparam int AW_DEF      = 8;
  localparam int DW_DEF      = 8;
  localparam int MAXWAIT_DEF = 4;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive refused host cycles.
// Raises starve once the host has waited MAXWAIT cycles.
module arb_starve_ctr #(
  parameter int MAXWAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic host_req,
  input  logic pick_host,
  output logic starve
);

  logic [3:0] wait_q, wait_d;

  assign starve = (wait_q == 4'(MAXWAIT));

  always_comb begin
    wait_d = '0;
    if (host_req && !pick_host)
      wait_d = starve ? wait_q : wait_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_q <= '0;
    else       wait_q <= wait_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dat_mem between the CPU load/store path and a host port.
// CPU keeps one-cycle timing; host waits at most MAXWAIT cycles.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int MAXWAIT = MAXWAIT_DEF,
  parameter int SW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_lock,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [SW-1:0] stall_cycles
);

  mem_req_t cpu_r, host_r, sel_r;
  logic     starve, pick_host;

  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [SW-1:0] stall_q, stall_d;

  assign cpu_r  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign host_r = '{we: host_we, addr: host_addr, wdata: host_wdata};

  arb_starve_ctr #(
    .MAXWAIT (MAXWAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .host_req  (host_req),
    .pick_host (pick_host),
    .starve    (starve)
  );

  // Reset gating here keeps gnt, stall and wr_en quiet during reset.
  assign pick_host = host_req & ~reset
                   & (~cpu_req | host_lock | starve);

  assign host_gnt  = pick_host;
  assign cpu_stall = cpu_req & pick_host;

  always_comb begin
    sel_r     = cpu_r;
    mem_wr_en = cpu_req & cpu_we & ~reset;
    if (pick_host) begin
      sel_r     = host_r;
      mem_wr_en = host_we;
    end
  end

  assign mem_addr  = sel_r.addr;
  assign mem_din   = sel_r.wdata;
  assign cpu_rdata = mem_dout;

  always_comb begin
    rvalid_d = pick_host & ~host_we;
    rdata_d  = rvalid_d ? mem_dout : rdata_q;
    stall_d  = stall_q;
    if (cpu_stall && stall_q != '1)
      stall_d = stall_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      stall_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      stall_q  <= stall_d;
    end
  end

  assign host_rvalid  = rvalid_q;
  assign host_rdata   = rdata_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus random traffic
// against a shadow-memory and refusal-count model.
module tb_dmem_arbiter;

  localparam int MAXWAIT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, cpu_stall;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       host_lock, host_req, host_we, host_gnt, host_rvalid;
  logic [7:0] host_addr, host_wdata, host_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic [15:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [256];
  logic [7:0] shadow [256];
  int         refused;
  int         stalls;
  bit         exp_rv;
  logic [7:0] exp_rd;

  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_din;

  dmem_arbiter #(.MAXWAIT(MAXWAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .host_lock    (host_lock),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .stall_cycles (stall_cycles)
  );

  function automatic bit exp_grant();
    return !reset && host_req
      && (!cpu_req || host_lock || refused == MAXWAIT);
  endfunction

  task automatic model_commit();
    bit g;
    g = exp_grant();
    if (reset) begin
      refused = 0; exp_rv = 0; exp_rd = 0; stalls = 0;
    end else if (g) begin
      refused = 0;
      exp_rv = !host_we;
      if (host_we) shadow[host_addr] = host_wdata;
      else exp_rd = shadow[host_addr];
      if (cpu_req && stalls < 65535) stalls++;
    end else begin
      exp_rv = 0;
      refused = host_req ? refused + 1 : 0;
      if (cpu_req && cpu_we) shadow[cpu_addr] = cpu_wdata;
    end
  endtask

  task automatic adv();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_lock = 0; host_req = 0; host_we = 0;
    host_addr = 0; host_wdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    adv();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h01; cpu_wdata = 8'hEE;
    host_req = 1; host_we = 1; host_addr = 8'h02; host_wdata = 8'hDD;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got=%b exp=0", host_gnt); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got=%b exp=0", cpu_stall); end
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wren got=%b exp=0", mem_wr_en); end
    adv();
    reset = 0;
    idle();
    @(negedge clk);
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got=%b exp=0", host_rvalid); end
    checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", host_rdata); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL rst_stallcnt got=%0d exp=0", stall_cycles); end
    adv();
  endtask

  task automatic test_host_only();
    do_reset();
    host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'h5A;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL ho_wgnt got=%b exp=1", host_gnt); end
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'h10 || mem_din !== 8'h5A) begin errors++; $display("FAIL ho_wbus got=%b/%h/%h exp=1/10/5A", mem_wr_en, mem_addr, mem_din); end
    adv();
    host_we = 0; host_wdata = 0;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b1) begin errors++; $display("FAIL ho_rgnt got=%b exp=1", host_gnt); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL ho_wr_rvalid got=%b exp=0", host_rvalid); end
    adv();
    host_req = 0;
    @(negedge clk);
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 8'h5A) begin errors++; $display("FAIL ho_read got=%b/%h exp=1/5A", host_rvalid, host_rdata); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL ho_stallcnt got=%0d exp=0", stall_cycles); end
    adv();
  endtask

  task automatic test_cpu_only();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 8'h33;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || mem_wr_en !== 1'b1) begin errors++; $display("FAIL co_store got=%b/%b exp=0/1", cpu_stall, mem_wr_en); end
    adv();
    cpu_we = 0; cpu_wdata = 0;
    @(negedge clk);
    checks++; if (cpu_rdata !== 8'h33 || cpu_stall !== 1'b0) begin errors++; $display("FAIL co_load got=%h/%b exp=33/0", cpu_rdata, cpu_stall); end
    adv();
    idle();
    @(negedge clk);
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL co_stallcnt got=%0d exp=0", stall_cycles); end
    adv();
  endtask

  task automatic test_starve();
    do_reset();
    cpu_req = 1; cpu_addr = 8'h30;
    host_req = 1; host_addr = 8'h31;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (host_gnt !== (c == 4)) begin errors++; $display("FAIL sv_gnt c=%0d got=%b exp=%b", c, host_gnt, c == 4); end
      checks++; if (cpu_stall !== (c == 4)) begin errors++; $display("FAIL sv_stall c=%0d got=%b exp=%b", c, cpu_stall, c == 4); end
      adv();
    end
    idle();
    @(negedge clk);
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL sv_stallcnt got=%0d exp=1", stall_cycles); end
    adv();
  endtask

  task automatic test_lock();
    int gnts;
    int stl;
    gnts = 0; stl = 0;
    do_reset();
    cpu_req = 1; cpu_addr = 8'h60;
    host_lock = 1; host_req = 1; host_we = 1;
    for (int i = 0; i < 8; i++) begin
      host_addr = 8'h70 + 8'(i);
      host_wdata = 8'(i * 17);
      @(negedge clk);
      gnts += int'(host_gnt);
      stl += int'(cpu_stall);
      adv();
    end
    idle();
    @(negedge clk);
    checks++; if (gnts != 8 || stl != 8) begin errors++; $display("FAIL lk_count gnt=%0d stall=%0d exp=8/8", gnts, stl); end
    checks++; if (stall_cycles !== 16'd8) begin errors++; $display("FAIL lk_stallcnt got=%0d exp=8", stall_cycles); end
    checks++; if (mem[8'h77] !== 8'd119) begin errors++; $display("FAIL lk_data got=%h exp=77", mem[8'h77]); end
    adv();
  endtask

  task automatic test_conflict();
    do_reset();
    cpu_req = 1; cpu_addr = 8'h40;
    host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'hC3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (cpu_stall !== (c == 4)) begin errors++; $display("FAIL cf_stall c=%0d got=%b exp=%b", c, cpu_stall, c == 4); end
      adv();
    end
    host_req = 0; host_we = 0;
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 8'hC3) begin errors++; $display("FAIL cf_replay got=%b/%h exp=0/C3", cpu_stall, cpu_rdata); end
    adv();
    idle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h51; cpu_wdata = 8'h11;
    host_req = 1; host_we = 1; host_addr = 8'h50; host_wdata = 8'h77;
    repeat (3) adv();
    reset = 1;
    @(negedge clk);
    checks++; if (host_gnt !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL rw_rst got=%b/%b exp=0/0", host_gnt, mem_wr_en); end
    adv();
    reset = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (host_gnt !== (c == 4)) begin errors++; $display("FAIL rw_gnt c=%0d got=%b exp=%b", c, host_gnt, c == 4); end
      adv();
    end
    idle();
  endtask

  task automatic test_random();
    bit pend;
    bit g;
    bit lock_on;
    pend = 0; lock_on = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      if (!cpu_stall || !cpu_req) begin
        cpu_req = ($urandom_range(0, 9) < 7);
        cpu_we = $urandom_range(0, 1);
        cpu_addr = 8'h80 + 8'($urandom_range(0, 7));
        cpu_wdata = 8'($urandom);
      end
      if ($urandom_range(0, 19) == 0) lock_on = !lock_on;
      host_lock = lock_on;
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1;
        host_we = $urandom_range(0, 1);
        host_addr = 8'h80 + 8'($urandom_range(0, 7));
        host_wdata = 8'($urandom);
      end
      host_req = pend;
      @(negedge clk);
      g = exp_grant();
      checks++; if (host_gnt !== g) begin errors++; $display("FAIL rn_gnt n=%0d got=%b exp=%b", n, host_gnt, g); end
      checks++; if (cpu_stall !== (g && cpu_req)) begin errors++; $display("FAIL rn_stall n=%0d got=%b exp=%b", n, cpu_stall, g && cpu_req); end
      checks++; if (mem_wr_en !== (!reset && (g ? host_we : cpu_req && cpu_we))) begin errors++; $display("FAIL rn_wren n=%0d got=%b", n, mem_wr_en); end
      if (cpu_req && !g && !reset) begin
        checks++; if (cpu_rdata !== shadow[cpu_addr]) begin errors++; $display("FAIL rn_cpurd n=%0d got=%h exp=%h", n, cpu_rdata, shadow[cpu_addr]); end
      end
      checks++; if (host_rvalid !== exp_rv) begin errors++; $display("FAIL rn_rvalid n=%0d got=%b exp=%b", n, host_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (host_rdata !== exp_rd) begin errors++; $display("FAIL rn_rdata n=%0d got=%h exp=%h", n, host_rdata, exp_rd); end
      end
      checks++; if (stall_cycles !== 16'(stalls)) begin errors++; $display("FAIL rn_stallcnt n=%0d got=%0d exp=%0d", n, stall_cycles, stalls); end
      if (g) pend = 0;
      adv();
    end
    reset = 0;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    refused = 0; stalls = 0; exp_rv = 0; exp_rd = 0;
    idle();
    reset = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_host_only();
    test_cpu_only();
    test_starve();
    test_lock();
    test_conflict();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
